// File: rtl/rf_pulse_gen.sv
// Framed RF pulse and sh_en strobe generator for exercising fsm_sync.
// Define RF_JITTER_EN to enable LFSR-driven +/-2 step frame and position jitter.
module rf_pulse_gen #(
  parameter int              CNT_W         = 16,
  parameter int              PERIOD_CYC    = 10000,
  parameter int              POS_CYC       = 3000,
  parameter int              HIGH_CYC      = 1,
  parameter int              PER_STEP      = 100,
  parameter int              POS_STEP      = 30,
  parameter int              SH_PERIOD_CYC = 5000,
  parameter logic [15:0]     LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] n_frames,
  output logic             rfin,
  output logic             sh_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  if (!(((POS_CYC - 2 * POS_STEP) >= 1) &&
        ((POS_CYC + 2 * POS_STEP) + HIGH_CYC < PERIOD_CYC - 2 * PER_STEP) &&
        (PERIOD_CYC + 2 * PER_STEP < 2 ** CNT_W) &&
        (HIGH_CYC >= 1) && (SH_PERIOD_CYC >= 2) &&
        (SH_PERIOD_CYC <= 2 ** CNT_W))) begin : g_param_err
    $error("rf_pulse_gen: inconsistent frame timing parameters");
  end

  typedef enum logic [1:0] {IDLE, PRE, HIGH, POST} state_t;

  localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_HIGH_LD = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] L_SH_LAST = CNT_W'(SH_PERIOD_CYC - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   r_post_len;
  logic [CNT_W-1:0]   r_n_frames, w_n_nxt;
  logic [CNT_W-1:0]   r_frame_cnt, w_frame_cnt_nxt;
  logic [CNT_W-1:0]   r_sh_cnt;
  logic               r_rfin, r_busy, r_done, r_sh_en;
  logic               w_draw, w_done_nxt;
  logic signed [31:0] w_r;
  logic [CNT_W-1:0]   w_adj_per, w_adj_pos, w_adj_post;

`ifdef RF_JITTER_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_r       = $signed(32'(r_lfsr % 16'd5)) - 32'sd2;

  // The draw uses the current LFSR value; the step happens on the same edge.
  always_ff @(posedge clk) begin
    if (!rst)        r_lfsr <= LFSR_SEED;
    else if (w_draw) r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end
`else
  assign w_r = 32'sd0;
`endif

  assign w_adj_per  = CNT_W'(PERIOD_CYC + w_r * PER_STEP);
  assign w_adj_pos  = CNT_W'(POS_CYC + w_r * POS_STEP);
  assign w_adj_post = w_adj_per - w_adj_pos - CNT_W'(HIGH_CYC);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_n_nxt         = r_n_frames;
    w_frame_cnt_nxt = r_frame_cnt;
    w_draw          = 1'b0;
    w_done_nxt      = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (start) begin
          w_n_nxt         = n_frames;
          w_frame_cnt_nxt = L_ONE;
          w_draw          = 1'b1;
          w_cnt_nxt       = w_adj_pos - L_ONE;
          w_state_nxt     = PRE;
        end
        PRE: if (r_cnt == '0) begin
          w_cnt_nxt   = L_HIGH_LD;
          w_state_nxt = HIGH;
        end else begin
          w_cnt_nxt = r_cnt - L_ONE;
        end
        HIGH: if (r_cnt == '0) begin
          w_cnt_nxt   = r_post_len - L_ONE;
          w_state_nxt = POST;
        end else begin
          w_cnt_nxt = r_cnt - L_ONE;
        end
        POST: if (r_cnt == '0) begin
          if ((r_n_frames != '0) && (r_frame_cnt == r_n_frames)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            // Back-to-back frame: the next frame's first PRE cycle follows directly.
            w_draw          = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt + L_ONE;
            w_cnt_nxt       = w_adj_pos - L_ONE;
            w_state_nxt     = PRE;
          end
        end else begin
          w_cnt_nxt = r_cnt - L_ONE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
      r_rfin      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_rfin      <= (w_state_nxt == HIGH);
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= w_done_nxt;
    end
  end

  // Phase counter and latched run parameters are only meaningful outside IDLE.
  always_ff @(posedge clk) begin
    r_cnt      <= w_cnt_nxt;
    r_n_frames <= w_n_nxt;
    if (w_draw) r_post_len <= w_adj_post;
  end

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      r_sh_cnt <= '0;
      r_sh_en  <= 1'b0;
    end else if (r_sh_cnt == L_SH_LAST) begin
      r_sh_cnt <= '0;
      r_sh_en  <= 1'b1;
    end else begin
      r_sh_cnt <= r_sh_cnt + L_ONE;
      r_sh_en  <= 1'b0;
    end
  end

  assign rfin      = r_rfin;
  assign sh_en     = r_sh_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_rf_pulse_gen.sv
// Scoreboard bench for rf_pulse_gen: expected rise times are queued at start and popped on each rfin pulse.
module tb_rf_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, start_a, rfin_a, sh_en_a, busy_a, done_a;
  logic [15:0] n_a, frame_cnt_a;
  logic        en_b, start_b, rfin_b, sh_en_b, busy_b, done_b;
  logic [3:0]  n_b, frame_cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int fc; int rise; } ev_t;
  ev_t sb_q[$];

`ifdef RF_JITTER_EN
  logic [15:0] m_lfsr = 16'hACE1;
`endif

  always #5 clk = ~clk;

  rf_pulse_gen #(
    .CNT_W(16), .PERIOD_CYC(100), .POS_CYC(30), .HIGH_CYC(1),
    .PER_STEP(5), .POS_STEP(3), .SH_PERIOD_CYC(5000), .LFSR_SEED(16'hACE1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .start(start_a), .n_frames(n_a),
    .rfin(rfin_a), .sh_en(sh_en_a), .busy(busy_a), .done(done_a), .frame_cnt(frame_cnt_a)
  );

  rf_pulse_gen #(
    .CNT_W(4), .PERIOD_CYC(12), .POS_CYC(4), .HIGH_CYC(2),
    .PER_STEP(1), .POS_STEP(1), .SH_PERIOD_CYC(5), .LFSR_SEED(16'hACE1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .start(start_b), .n_frames(n_b),
    .rfin(rfin_b), .sh_en(sh_en_b), .busy(busy_b), .done(done_b), .frame_cnt(frame_cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int draw_r();
`ifdef RF_JITTER_EN
    int r;
    r = int'(m_lfsr % 16'd5) - 2;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    return r;
`else
    return 0;
`endif
  endfunction

  // Frame 1 starts at k=1 (the cycle after the accepting edge).
  task automatic plan_frames(input int nfr, output int end_k);
    int s, r;
    ev_t e;
    s = 1;
    for (int i = 1; i <= nfr; i++) begin
      r = draw_r();
      e.fc = i;
      e.rise = s + 30 + 3 * r;
      sb_q.push_back(e);
      s = s + 100 + 5 * r;
    end
    end_k = s;
  endtask

  task automatic test_reset();
    rst = 1'b0; en_a = 1'b0; start_a = 1'b0; n_a = '0;
    en_b = 1'b0; start_b = 1'b0; n_b = '0;
    tick(); tick();
    n_cmp++; if (rfin_a !== 1'b0) begin n_bad++; $display("FAIL reset_rfin_a got=%b want=0", rfin_a); end
    n_cmp++; if (sh_en_a !== 1'b0) begin n_bad++; $display("FAIL reset_sh_en_a got=%b want=0", sh_en_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy_a got=%b want=0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done_a got=%b want=0", done_a); end
    n_cmp++; if (frame_cnt_a !== 16'd0) begin n_bad++; $display("FAIL reset_fc_a got=%0d want=0", frame_cnt_a); end
    n_cmp++; if ({rfin_b, sh_en_b, busy_b, done_b} !== 4'b0) begin n_bad++; $display("FAIL reset_b_flags got=%b want=0000", {rfin_b, sh_en_b, busy_b, done_b}); end
    n_cmp++; if (frame_cnt_b !== 4'd0) begin n_bad++; $display("FAIL reset_fc_b got=%0d want=0", frame_cnt_b); end
    rst = 1'b1; en_a = 1'b1;
    tick();
  endtask

  task automatic test_run_frames(input int nfr, input int poke_k);
    int end_k, start_k, fc_prev, per, off;
    ev_t e;
    sb_q.delete();
    plan_frames(nfr, end_k);
    n_a = 16'(nfr); start_a = 1'b1;
    tick();
    start_a = 1'b0;
    fc_prev = 0; start_k = 1;
    for (int k = 1; k <= end_k + 1; k++) begin
      start_a = (k == poke_k);
      if (k == poke_k) n_a = 16'd7;
      n_cmp++; if (busy_a !== (k < end_k)) begin n_bad++; $display("FAIL run_busy k=%0d got=%b want=%b", k, busy_a, (k < end_k)); end
      n_cmp++; if (done_a !== (k == end_k)) begin n_bad++; $display("FAIL run_done k=%0d got=%b want=%b", k, done_a, (k == end_k)); end
      if (k < end_k && int'(frame_cnt_a) != fc_prev) begin
        n_cmp++; if (int'(frame_cnt_a) != fc_prev + 1) begin n_bad++; $display("FAIL run_fc_step k=%0d got=%0d want=%0d", k, frame_cnt_a, fc_prev + 1); end
        if (k > 1) begin
          per = k - start_k;
          n_cmp++; if (per < 90 || per > 110 || (per - 100) % 5 != 0) begin n_bad++; $display("FAIL run_period k=%0d got=%0d want=90..110 step 5", k, per); end
        end
        start_k = k; fc_prev = int'(frame_cnt_a);
      end
      if (rfin_a) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++; $display("FAIL run_rfin_extra k=%0d got=1 want=0", k);
        end else begin
          e = sb_q.pop_front();
          if (k != e.rise || fc_prev != e.fc) begin n_bad++; $display("FAIL run_rise got=k%0d/fc%0d want=k%0d/fc%0d", k, fc_prev, e.rise, e.fc); end
          off = k - start_k;
          n_cmp++; if (off < 24 || off > 36 || (off - 30) % 3 != 0) begin n_bad++; $display("FAIL run_offset k=%0d got=%0d want=24..36 step 3", k, off); end
        end
      end
      if (k == end_k) begin
        per = k - start_k;
        n_cmp++; if (per < 90 || per > 110 || (per - 100) % 5 != 0) begin n_bad++; $display("FAIL run_last_period got=%0d want=90..110 step 5", per); end
      end
      tick();
    end
    start_a = 1'b0; n_a = '0;
    n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL run_rise_missing got=%0d left want=0", sb_q.size()); end
  endtask

  task automatic test_en_abort();
    int end_k;
    bit found;
    ev_t e;
    sb_q.delete();
    plan_frames(2, end_k);
    n_a = 16'd3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    found = 1'b0;
    for (int k = 1; k <= 400 && !found; k++) begin
      if (rfin_a && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_cmp++; if (k != e.rise) begin n_bad++; $display("FAIL abort_rise got=%0d want=%0d", k, e.rise); end
        if (frame_cnt_a == 16'd2) found = 1'b1;
      end
      if (!found) tick();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL abort_reach got=timeout want=frame2 HIGH"); end
    en_a = 1'b0;
    tick();
    n_cmp++; if (rfin_a !== 1'b0) begin n_bad++; $display("FAIL abort_rfin got=%b want=0", rfin_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b want=0", busy_a); end
    repeat (3) begin
      n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL abort_done got=%b want=0", done_a); end
      tick();
    end
    n_cmp++; if (frame_cnt_a !== 16'd2) begin n_bad++; $display("FAIL abort_fc got=%0d want=2", frame_cnt_a); end
    en_a = 1'b1; n_a = 16'd1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    void'(draw_r());
    n_cmp++; if (frame_cnt_a !== 16'd1) begin n_bad++; $display("FAIL restart_fc got=%0d want=1", frame_cnt_a); end
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL restart_busy got=%b want=1", busy_a); end
    en_a = 1'b0;
    tick();
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL restart_abort_busy got=%b want=0", busy_a); end
    en_a = 1'b1;
    tick();
  endtask

  task automatic test_rst_mid_post();
    int end_k;
    bit found;
    ev_t e;
    sb_q.delete();
    plan_frames(1, end_k);
    n_a = 16'd3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    found = 1'b0;
    for (int k = 1; k <= 200 && !found; k++) begin
      if (rfin_a) begin
        found = 1'b1;
        e = sb_q.pop_front();
        n_cmp++; if (k != e.rise) begin n_bad++; $display("FAIL rst_rise got=%0d want=%0d", k, e.rise); end
      end else begin
        tick();
      end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rst_reach got=timeout want=rfin"); end
    repeat (5) tick();
    rst = 1'b0;
    tick();
    n_cmp++; if ({rfin_a, sh_en_a, busy_a, done_a} !== 4'b0) begin n_bad++; $display("FAIL rst_flags got=%b want=0000", {rfin_a, sh_en_a, busy_a, done_a}); end
    n_cmp++; if (frame_cnt_a !== 16'd0) begin n_bad++; $display("FAIL rst_fc got=%0d want=0", frame_cnt_a); end
    rst = 1'b1;
`ifdef RF_JITTER_EN
    m_lfsr = 16'hACE1;
`endif
    repeat (3) begin
      tick();
      n_cmp++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_after got=done%b/busy%b want=0/0", done_a, busy_a); end
    end
  endtask

  task automatic test_sh_en();
    en_a = 1'b0;
    tick();
    en_a = 1'b1;
    for (int j = 1; j <= 10001; j++) begin
      tick();
      n_cmp++; if (sh_en_a !== (j % 5000 == 0)) begin n_bad++; $display("FAIL sh_en j=%0d got=%b want=%b", j, sh_en_a, (j % 5000 == 0)); end
    end
    repeat (2000) tick();
    en_a = 1'b0;
    tick();
    n_cmp++; if (sh_en_a !== 1'b0) begin n_bad++; $display("FAIL sh_en_off got=%b want=0", sh_en_a); end
    en_a = 1'b1;
    for (int j = 1; j <= 5001; j++) begin
      tick();
      n_cmp++; if (sh_en_a !== (j == 5000)) begin n_bad++; $display("FAIL sh_en_rephase j=%0d got=%b want=%b", j, sh_en_a, (j == 5000)); end
    end
  endtask

  task automatic test_wrap();
    int fc_prev;
    bit saw_wrap, stop;
    en_b = 1'b1; n_b = 4'd0; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n_cmp++; if (frame_cnt_b !== 4'd1) begin n_bad++; $display("FAIL wrap_first_fc got=%0d want=1", frame_cnt_b); end
    fc_prev = 1; saw_wrap = 1'b0; stop = 1'b0;
    for (int k = 1; k <= 600 && !stop; k++) begin
      n_cmp++; if (done_b !== 1'b0 || busy_b !== 1'b1) begin n_bad++; $display("FAIL wrap_flags k=%0d got=done%b/busy%b want=0/1", k, done_b, busy_b); end
      if (int'(frame_cnt_b) != fc_prev) begin
        n_cmp++; if (int'(frame_cnt_b) != ((fc_prev + 1) % 16)) begin n_bad++; $display("FAIL wrap_step got=%0d want=%0d", frame_cnt_b, (fc_prev + 1) % 16); end
        if (fc_prev == 15 && frame_cnt_b == 4'd0) saw_wrap = 1'b1;
        fc_prev = int'(frame_cnt_b);
      end
      if (saw_wrap && frame_cnt_b == 4'd2) stop = 1'b1;
      else tick();
    end
    n_cmp++; if (!stop) begin n_bad++; $display("FAIL wrap_seen got=timeout want=15->0->2"); end
    en_b = 1'b0;
    tick();
    n_cmp++; if (busy_b !== 1'b0 || done_b !== 1'b0) begin n_bad++; $display("FAIL wrap_stop got=busy%b/done%b want=0/0", busy_b, done_b); end
  endtask

  initial begin
    test_reset();
    test_run_frames(3, 0);
    test_run_frames(2, 50);
    test_en_abort();
    test_rst_mid_post();
    test_run_frames(256, 0);
    test_sh_en();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_pulse_gen.md
Name: rf_pulse_gen

Overview:
- Stimulus/transmit side of the RF sync interface: emits framed `rfin` pulses and periodic `sh_en` strobes.
- These feed `fsm_sync` on silicon-level test setups and in loopback benches.
- Each frame is PERIOD_CYC ±jitter cycles long, with a HIGH_CYC-wide pulse placed at a programmable offset.
- Runs a programmed number of frames, or runs continuously.

Parameters:
- CNT_W, 16, width of all cycle/frame counters
- PERIOD_CYC, 10000, nominal frame length in clk cycles (1 ms at 10 MHz)
- POS_CYC, 3000, nominal cycles from frame start to `rfin` rise (30%)
- HIGH_CYC, 1, `rfin` high width in cycles (≥1)
- PER_STEP, 100, period change per jitter unit (1% of PERIOD_CYC)
- POS_STEP, 30, position change per jitter unit (1% of POS_CYC)
- SH_PERIOD_CYC, 5000, `sh_en` strobe interval in cycles (≥2)
- LFSR_SEED, 16'hACE1, nonzero LFSR seed

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- en  in  1  level enable; low aborts activity
- start  in  1  one-cycle request to begin a run
- n_frames  in  CNT_W  frames per run; 0 = continuous; sampled on accepted start
- rfin  out  1  registered RF pulse output
- sh_en  out  1  registered one-cycle shift-enable strobe
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse at normal run completion
- frame_cnt  out  CNT_W  frames begun in current run; wraps at 2^CNT_W

Behaviour:
- Reset (rst=0 at a clk edge):
  - `rfin`, `sh_en`, `busy`, `done` = 0; `frame_cnt` = 0.
  - FSM goes to IDLE; LFSR = LFSR_SEED; `sh_en` divider = 0.
  - Reset asserted mid-run aborts immediately; no `done` is produced.
- FSM states: IDLE, PRE, HIGH, POST.
  - IDLE: `start`=1 and `en`=1 at edge t accepts the run.
    - Latch `n_frames`; set `frame_cnt`=1; enter PRE at t+1.
    - `busy`=1 from t+1.
  - Frame start (entering PRE):
    - Draw r = (LFSR mod 5) − 2, range −2..+2, then advance the LFSR one step.
    - LFSR polynomial: x^16+x^14+x^13+x^11+1, Fibonacci form, shifting left.
    - adj_per = PERIOD_CYC + r·PER_STEP; adj_pos = POS_CYC + r·POS_STEP.
    - Signed arithmetic, result width CNT_W.
  - PRE lasts adj_pos cycles, then HIGH.
  - HIGH lasts HIGH_CYC cycles with `rfin`=1, then POST.
  - POST lasts adj_per − adj_pos − HIGH_CYC cycles.
  - The frame is exactly adj_per cycles, counted from its first PRE cycle.
  - End of POST:
    - If the last frame is complete (`frame_cnt`==latched n_frames, n≠0): go to IDLE, `busy`=0, `done`=1 for one cycle.
    - Otherwise: next frame starts with no gap, `frame_cnt`+1.
  - `rfin` timing: rises on the cycle after the adj_pos-th PRE cycle; `rfin`=1 only in HIGH.
- `start` while `busy` is ignored; `start` with `en`=0 is ignored.
- `en` falls mid-run:
  - Next edge: go to IDLE, `rfin`=0, `busy`=0, no `done`.
  - `frame_cnt` holds its value; the LFSR keeps its state.
- n_frames=0: frames repeat until `en` falls; `frame_cnt` wraps 2^CNT_W−1→0 without side effects.
- `sh_en`:
  - Free-running divider, independent of the FSM and of `start`.
  - Counts while `en`=1; cleared while `en`=0.
  - Pulses one cycle when the count reaches SH_PERIOD_CYC−1, then wraps to 0.
  - First pulse comes SH_PERIOD_CYC cycles after `en` rises.
- Elaboration check (`$error`) unless all hold:
  - (POS_CYC − 2·POS_STEP) ≥ 1
  - (POS_CYC + 2·POS_STEP) + HIGH_CYC < PERIOD_CYC − 2·PER_STEP
  - all derived values fit CNT_W

Optional Feature:
- Macro: RF_JITTER_EN.
- Defined: jitter exactly as above.
- Undefined:
  - LFSR is not instantiated; r ≡ 0.
  - Every frame is exactly PERIOD_CYC cycles with the rise at POS_CYC.
  - All other behaviour is identical.

Test Plan:
- RF_JITTER_EN undefined, PERIOD_CYC=100, POS_CYC=30, HIGH_CYC=1, n_frames=3, start at t:
  - `rfin` high only at t+31, t+131, t+231.
  - `busy` high t+1..t+300; `done` pulse at t+301; `frame_cnt` reads 1,2,3.
- Jitter on, defaults, 256 frames:
  - Every period ∈ {9800,9900,10000,10100,10200}.
  - Every rise offset ∈ {2940..3060 step 30}.
  - r sequence matches a reference LFSR model seeded 16'hACE1.
- `en` dropped during the HIGH cycle of frame 2:
  - `rfin`=0 and `busy`=0 next cycle; no `done`; `frame_cnt`=2.
  - A subsequent `start` restarts with `frame_cnt`=1.
- `start` pulsed while `busy`: ignored, frame timing unchanged. `rst`=0 mid-POST: all outputs 0 next cycle.
- SH_PERIOD_CYC=5000, `en` raised at t0:
  - `sh_en` pulses at t0+5000, t0+10000, each 1 cycle.
  - `en` low for 1 cycle resets the phase.
- n_frames=0, CNT_W=4, short frames:
  - `frame_cnt` wraps 15→0 and the run continues; `done` never asserts.
